// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg : opcodes, FSM states and IR field positions for the control unit
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package proc_pkg;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MVNZ = 3'b100
    } opcode_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam int unsigned OP_MSB = 8;
    localparam int unsigned OP_LSB = 6;
    localparam int unsigned X_MSB  = 5;
    localparam int unsigned X_LSB  = 3;
    localparam int unsigned Y_MSB  = 2;
    localparam int unsigned Y_LSB  = 0;

endpackage

`default_nettype wire

// File: rtl/dec3to8.sv
// ---------------------------------------------------------------------------
// dec3to8 : 3-bit to one-hot 8-bit decoder with enable
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dec3to8 (
    input  logic       en_i,
    input  logic [2:0] sel_i,
    output logic [7:0] y_o
);

    assign y_o = en_i ? (8'b0000_0001 << sel_i) : 8'b0000_0000;

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit : T0..T3 sequencing FSM for the 9-bit processor datapath.
// Optional mvnz support via macro CONTROL_UNIT_MVNZ_EN.  Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module control_unit
    import proc_pkg::*;
#(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Run,
    input  logic [DW-1:0] Din,
    input  logic [DW-1:0] G,
    output logic [7:0]    Rin,
    output logic [7:0]    Rout,
    output logic          Ain,
    output logic          Gin,
    output logic          Gout,
    output logic          Dinout,
    output logic          AddSub,
    output logic          Done,
    output logic [DW-1:0] IR
);

    state_t        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;

    logic [2:0] op;
    logic [2:0] x_sel;
    logic [2:0] y_sel;
    logic [2:0] rout_sel;
    logic       rin_en;
    logic       rout_en;

    assign op    = ir_q[OP_MSB:OP_LSB];
    assign x_sel = ir_q[X_MSB:X_LSB];
    assign y_sel = ir_q[Y_MSB:Y_LSB];
    assign IR    = ir_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_sel = y_sel;
        Ain      = 1'b0;
        Gin      = 1'b0;
        Gout     = 1'b0;
        Dinout   = 1'b0;
        AddSub   = 1'b0;
        Done     = 1'b0;

        case (state_q)
            T0: begin
                if (Run) begin
                    ir_d    = Din;
                    state_d = T1;
                end
            end
            T1: begin
                state_d = T0;
                case (op)
                    OP_MV: begin
                        rout_en = 1'b1;
                        rin_en  = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_MVI: begin
                        Dinout = 1'b1;
                        rin_en = 1'b1;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        // First operand is the destination register itself.
                        rout_sel = x_sel;
                        rout_en  = 1'b1;
                        Ain      = 1'b1;
                        state_d  = T2;
                    end
`ifdef CONTROL_UNIT_MVNZ_EN
                    OP_MVNZ: begin
                        rout_en = (G != '0);
                        rin_en  = (G != '0);
                        Done    = 1'b1;
                    end
`endif
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                rout_en = 1'b1;
                Gin     = 1'b1;
                AddSub  = (op == OP_SUB);
                state_d = T3;
            end
            T3: begin
                Gout    = 1'b1;
                rin_en  = 1'b1;
                Done    = 1'b1;
                state_d = T0;
            end
            default: begin
                state_d = T0;
            end
        endcase
    end

`ifndef CONTROL_UNIT_MVNZ_EN
    logic unused_g;
    assign unused_g = ^G;
`endif

    dec3to8 u_dec_rin (
        .en_i  (rin_en),
        .sel_i (x_sel),
        .y_o   (Rin)
    );

    dec3to8 u_dec_rout (
        .en_i  (rout_en),
        .sel_i (rout_sel),
        .y_o   (Rout)
    );

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit : directed self-checking bench with a small datapath model
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_control_unit;
    import proc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Run = 1'b0;
    logic [8:0] Din = '0;
    logic [8:0] G   = '0;
    logic [7:0] Rin, Rout;
    logic       Ain, Gin, Gout, Dinout, AddSub, Done;
    logic [8:0] IR;

    int errors = 0;
    int checks = 0;

    logic [8:0] R [8];
    logic [8:0] A, Greg, bus;

    always #5 clk = ~clk;

    control_unit #(.DW(9)) dut (
        .clk    (clk),
        .rst    (rst),
        .Run    (Run),
        .Din    (Din),
        .G      (G),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .Dinout (Dinout),
        .AddSub (AddSub),
        .Done   (Done),
        .IR     (IR)
    );

    // Reference datapath driven by the DUT controls.
    always_comb begin
        bus = '0;
        if (Dinout) bus = Din;
        else if (Gout) bus = Greg;
        else for (int i = 0; i < 8; i++) if (Rout[i]) bus = bus | R[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (Rin[i]) R[i] <= bus;
        if (Ain) A <= bus;
        if (Gin) Greg <= AddSub ? (A - bus) : (A + bus);
    end

    wire [21:0] ctl = {Rin, Rout, Ain, Gin, Gout, Dinout, AddSub, Done};

    function automatic logic [21:0] mk(input logic [7:0] rin, input logic [7:0] rout,
                                       input logic ain, input logic gin, input logic gout,
                                       input logic dinout, input logic addsub, input logic done);
        return {rin, rout, ain, gin, gout, dinout, addsub, done};
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3 rst = 1'b0;
        #1;
        checks++; if (ctl !== 22'd0) begin errors++; $display("FAIL reset_ctl got=%h exp=%h", ctl, 22'd0); end
        checks++; if (IR !== 9'd0) begin errors++; $display("FAIL reset_ir got=%h exp=%h", IR, 9'd0); end
        checks++; if (dut.state_q !== T0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dut.state_q); end
        cyc;
        rst = 1'b1;
        #1;
        checks++; if (ctl !== 22'd0) begin errors++; $display("FAIL reset_release_ctl got=%h exp=0", ctl); end
    endtask

    task automatic test_mvi;
        logic [21:0] exp;
        Din = 9'b001_000_000; Run = 1'b1;
        cyc;
        Run = 1'b0; Din = 9'd5;
        #1;
        exp = mk(8'h01, 8'h00, 0, 0, 0, 1, 0, 1);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL mvi_t1 got=%h exp=%h", ctl, exp); end
        checks++; if (IR !== 9'b001_000_000) begin errors++; $display("FAIL mvi_ir got=%h exp=%h", IR, 9'b001_000_000); end
        cyc;
        checks++; if (R[0] !== 9'd5) begin errors++; $display("FAIL mvi_r0 got=%0d exp=5", R[0]); end
        checks++; if (ctl !== 22'd0) begin errors++; $display("FAIL mvi_t0 got=%h exp=0", ctl); end
    endtask

    task automatic test_mv;
        logic [21:0] exp;
        Din = 9'b000_001_000; Run = 1'b1;
        cyc;
        Run = 1'b0;
        #1;
        exp = mk(8'h02, 8'h01, 0, 0, 0, 0, 0, 1);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL mv_t1 got=%h exp=%h", ctl, exp); end
        cyc;
        checks++; if (R[1] !== 9'd5) begin errors++; $display("FAIL mv_r1 got=%0d exp=5", R[1]); end
    endtask

    task automatic test_alu(input logic [8:0] instr, input logic is_sub, input logic [8:0] exp_r0);
        logic [21:0] exp;
        Din = instr; Run = 1'b1;
        cyc;
        Run = 1'b0;
        #1;
        exp = mk(8'h00, 8'h01, 1, 0, 0, 0, 0, 0);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL alu%0d_t1 got=%h exp=%h", is_sub, ctl, exp); end
        cyc;
        exp = mk(8'h00, 8'h02, 0, 1, 0, 0, is_sub, 0);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL alu%0d_t2 got=%h exp=%h", is_sub, ctl, exp); end
        cyc;
        exp = mk(8'h01, 8'h00, 0, 0, 1, 0, 0, 1);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL alu%0d_t3 got=%h exp=%h", is_sub, ctl, exp); end
        cyc;
        checks++; if (R[0] !== exp_r0) begin errors++; $display("FAIL alu%0d_r0 got=%0d exp=%0d", is_sub, R[0], exp_r0); end
        checks++; if (ctl !== 22'd0) begin errors++; $display("FAIL alu%0d_t0 got=%h exp=0", is_sub, ctl); end
    endtask

    task automatic test_back_to_back;
        logic [21:0] exp;
        int done_cnt;
        done_cnt = 0;
        Din = 9'b000_010_000; Run = 1'b1;
        cyc;
        exp = mk(8'h04, 8'h01, 0, 0, 0, 0, 0, 1);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL b2b_mv got=%h exp=%h", ctl, exp); end
        done_cnt += int'(Done);
        Din = 9'b010_010_010;
        cyc;
        checks++; if (ctl !== 22'd0) begin errors++; $display("FAIL b2b_t0 got=%h exp=0", ctl); end
        checks++; if (R[2] !== 9'd5) begin errors++; $display("FAIL b2b_r2_mv got=%0d exp=5", R[2]); end
        done_cnt += int'(Done);
        cyc;
        checks++; if (IR !== 9'b010_010_010) begin errors++; $display("FAIL b2b_ir got=%h exp=%h", IR, 9'b010_010_010); end
        exp = mk(8'h00, 8'h04, 1, 0, 0, 0, 0, 0);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL b2b_add_t1 got=%h exp=%h", ctl, exp); end
        done_cnt += int'(Done);
        cyc;
        exp = mk(8'h00, 8'h04, 0, 1, 0, 0, 0, 0);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL b2b_add_t2 got=%h exp=%h", ctl, exp); end
        done_cnt += int'(Done);
        cyc;
        exp = mk(8'h04, 8'h00, 0, 0, 1, 0, 0, 1);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL b2b_add_t3 got=%h exp=%h", ctl, exp); end
        done_cnt += int'(Done);
        Run = 1'b0;
        cyc;
        checks++; if (R[2] !== 9'd10) begin errors++; $display("FAIL b2b_r2_add got=%0d exp=10", R[2]); end
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
    endtask

    task automatic test_opcode100;
        logic [21:0] exp;
        logic [8:0]  exp_r3;
        Din = 9'b100_011_001; Run = 1'b1; G = 9'd0;
        cyc;
        Run = 1'b0;
        #1;
        exp = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL op100_g0 got=%h exp=%h", ctl, exp); end
        cyc;
        checks++; if (R[3] !== 9'd0) begin errors++; $display("FAIL op100_g0_r3 got=%0d exp=0", R[3]); end
        Run = 1'b1; G = 9'd3;
        cyc;
        Run = 1'b0;
        #1;
`ifdef CONTROL_UNIT_MVNZ_EN
        exp    = mk(8'h08, 8'h02, 0, 0, 0, 0, 0, 1);
        exp_r3 = 9'd5;
`else
        exp    = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
        exp_r3 = 9'd0;
`endif
        checks++; if (ctl !== exp) begin errors++; $display("FAIL op100_g3 got=%h exp=%h", ctl, exp); end
        cyc;
        checks++; if (R[3] !== exp_r3) begin errors++; $display("FAIL op100_g3_r3 got=%0d exp=%0d", R[3], exp_r3); end
        G = 9'd0;
        Din = 9'b111_011_001; Run = 1'b1;
        cyc;
        Run = 1'b0;
        #1;
        exp = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL op111_nop got=%h exp=%h", ctl, exp); end
        cyc;
        checks++; if (ctl !== 22'd0) begin errors++; $display("FAIL op111_t0 got=%h exp=0", ctl); end
    endtask

    task automatic test_reset_mid_add;
        logic [21:0] exp;
        Din = 9'b010_000_001; Run = 1'b1;
        cyc;
        Run = 1'b0;
        cyc;
        exp = mk(8'h00, 8'h02, 0, 1, 0, 0, 0, 0);
        checks++; if (ctl !== exp) begin errors++; $display("FAIL rstmid_t2 got=%h exp=%h", ctl, exp); end
        rst = 1'b0;
        #1;
        checks++; if (Gin !== 1'b0) begin errors++; $display("FAIL rstmid_gin got=%b exp=0", Gin); end
        checks++; if (ctl !== 22'd0) begin errors++; $display("FAIL rstmid_ctl got=%h exp=0", ctl); end
        checks++; if (IR !== 9'd0) begin errors++; $display("FAIL rstmid_ir got=%h exp=0", IR); end
        checks++; if (dut.state_q !== T0) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", dut.state_q); end
        cyc;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc;
            checks++; if (ctl !== 22'd0) begin errors++; $display("FAIL rstmid_idle%0d got=%h exp=0", k, ctl); end
            checks++; if (dut.state_q !== T0) begin errors++; $display("FAIL rstmid_idle_state%0d got=%0d exp=0", k, dut.state_q); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) R[i] = '0;
        A    = '0;
        Greg = '0;
        test_reset();
        test_mvi();
        test_mv();
        test_alu(9'b010_000_001, 1'b0, 9'd10);
        test_alu(9'b011_000_001, 1'b1, 9'd5);
        test_back_to_back();
        test_opcode100();
        test_reset_mid_add();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

Sequencing FSM that drives the 9-bit processor datapath: latches each instruction word from `Din`, decodes it and emits the one-hot register enables, bus-source selects, `AddSub` and `Done` for every cycle. Sits directly upstream of the datapath: all of that block's control inputs come from here, and its `G` output returns here for conditional moves.

## Interface
- `DW`, default 9: data and instruction width; only 9 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Run`  in  1  start request; sampled only in state T0.
- `Din`  in  DW  instruction word in T0; immediate operand in T1 for `mvi` (consumed by the datapath).
- `G`  in  DW  datapath G register; used only by `mvnz`.
- `Rin`  out  8  one-hot register load enables; bit i drives datapath `Ri in`.
- `Rout`  out  8  one-hot register bus-drive selects; bit i drives datapath `Ri out`.
- `Ain`, `Gin`, `Gout`, `Dinout`, `AddSub`  out  1 each  datapath controls.
- `Done`  out  1  high during the final cycle of an instruction.
- `IR`  out  DW  current instruction register, for debug.

## Operation
- IR format: `[8:6]` opcode, `[5:3]` X (destination), `[2:0]` Y (source).
- Opcodes:
  - 000 `mv` Rx←Ry
  - 001 `mvi` Rx←Din
  - 010 `add` Rx←Rx+Ry
  - 011 `sub` Rx←Rx−Ry
  - 100 `mvnz` (see Configuration)
  - 101–111 reserved, executed as NOP.
- States T0, T1, T2, T3, held in a 2-bit state register.
- T0:
  - All outputs deasserted.
  - If `Run`=1, IR←Din and go to T1; otherwise stay in T0.
- T1:
  - `mv`: Rout[Y], Rin[X], Done; go to T0.
  - `mvi`: Dinout, Rin[X], Done; go to T0.
  - `add`/`sub`: Rout[X], Ain; go to T2.
  - NOP: Done only; go to T0.
- T2: Rout[Y], Gin, with AddSub=0 for `add` and 1 for `sub`; go to T3.
- T3: Gout, Rin[X], Done; go to T0.
- Outputs are combinational from state and IR (Moore on IR). At most one of Rout/Gout/Dinout is high in any cycle.
- AddSub is 0 in every cycle except T2 of `sub`.
- X==Y is legal:
  - `add R2,R2` doubles R2.
  - `mv R3,R3` drives and loads the same register; no special handling.
- `Run` is ignored outside T0. If `Run` is held high continuously, the next instruction is latched in the T0 immediately after the cycle in which `Done` was high.
- Reset: state←T0, IR←0, immediately on `rst` falling, including mid-instruction. All outputs then read 0. Outputs are not glitch-protected during reset assertion.

## Timing
- Latency from the `Run`-sampling edge to `Done` high:
  - `mv`/`mvi`/NOP: Done in the 1st following cycle (2 cycles total including T0).
  - `add`/`sub`: Done in the 3rd following cycle (4 cycles total).
- The datapath register write happens at the edge that ends the `Done` cycle.
- `Din` must hold the immediate throughout T1 of `mvi`.
- `G` is sampled combinationally in T1 of `mvnz`.

## Configuration
- Macro: `CONTROL_UNIT_MVNZ_EN`.
- Defined: opcode 100 is `mvnz`.
  - In T1, if G≠0: Rout[Y], Rin[X], Done.
  - If G==0: Done only, no register load.
  - Go to T0 in both cases.
- Undefined: opcode 100 is a reserved NOP, the `G` port is present but unused, and no logic depends on it.

## Structure
- Shared package `proc_pkg`:
  - opcode enum (`OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_MVNZ`)
  - state enum (`T0`..`T3`)
  - field position constants for opcode/X/Y.
- One sub-module `dec3to8`: 3-bit to one-hot 8-bit decoder with enable. Two instances, one for Rin[X] and one for Rout of the selected X/Y field.

## Test plan
- Reset mid-`add`:
  - Stimulus: assert `rst`=0 during T2.
  - Required: state T0, IR=0, Gin=0 at once. After release with Run=0, all outputs stay 0.
- `mvi R0,#5`:
  - Stimulus: Din=9'b001000000, Run=1, then Din=5 in T1.
  - Required: T1 shows Dinout=1, Rin=8'b00000001, Done=1. The datapath holds R0=5 after that edge.
- `mv R1,R0`:
  - Stimulus: Din=9'b000001000, with R0=5.
  - Required: T1 shows Rout=8'b00000001, Rin=8'b00000010, Done=1. Then R1=5.
- `add R0,R1` then `sub R0,R1`:
  - Stimulus: R0=5, R1=5.
  - Required: add gives the sequence T1 Ain, T2 Gin with AddSub=0, T3 Gout+Rin[0]+Done, leaving R0=10. Sub then leaves R0=5, with AddSub=1 only in T2.
- Back-to-back with Run held high:
  - Stimulus: `mv` then `add`.
  - Required: `add` is latched in the T0 immediately after `mv`'s Done cycle. Done pulses once per instruction.
- Opcode 100, macro defined vs undefined:
  - Defined: G=0 gives Rin=0 with Done=1; G=3 gives Rin[X]=1.
  - Undefined: always NOP.
